input_port_router: RTL and testbench

- Upstream stage of `round_robin_arbiter`; one instance per router input port.
- Accepts packets from a link, buffers them in a small FIFO and computes an XY dimension-ordered route for each packet as it is written.
- Presents the head packet's route as a 5-bit one-hot request to the arbiter and holds it until the port is granted.
- On grant, pops the head packet and drives it to the crossbar.

---
 rtl/router_pkg.sv | 27 ++
 rtl/xy_route_calc.sv | 33 +++
 rtl/input_port_router.sv | 122 ++++++++++++
 tb/tb_input_port_router.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg : shared direction encodings and packet field positions.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package router_pkg;

  localparam int COORD_W = 4;

  localparam int DST_X_MSB = 7;
  localparam int DST_X_LSB = 4;
  localparam int DST_Y_MSB = 3;
  localparam int DST_Y_LSB = 0;

  typedef logic [4:0]         dir_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam dir_t DIR_L = 5'b00001;
  localparam dir_t DIR_N = 5'b00010;
  localparam dir_t DIR_E = 5'b00100;
  localparam dir_t DIR_S = 5'b01000;
  localparam dir_t DIR_W = 5'b10000;

endpackage

`default_nettype wire

// File: rtl/xy_route_calc.sv
// ----------------------------------------------------------------------------
// xy_route_calc : combinational XY dimension-ordered route, one-hot output.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module xy_route_calc
  import router_pkg::*;
#(
  parameter int CUR_X = 0,
  parameter int CUR_Y = 0
) (
  input  logic [COORD_W-1:0] dst_x,
  input  logic [COORD_W-1:0] dst_y,
  output logic [4:0]         dir
);

  localparam coord_t CX = coord_t'(CUR_X);
  localparam coord_t CY = coord_t'(CUR_Y);

  // X is resolved fully before Y, which keeps the mesh deadlock-free.
  always_comb begin
    dir = DIR_L;
    if (dst_x > CX)      dir = DIR_E;
    else if (dst_x < CX) dir = DIR_W;
    else if (dst_y > CY) dir = DIR_N;
    else if (dst_y < CY) dir = DIR_S;
    else                 dir = DIR_L;
  end

endmodule

`default_nettype wire

// File: rtl/input_port_router.sv
// ----------------------------------------------------------------------------
// input_port_router : packet FIFO with write-side XY route and one-hot request.
// Optional macro ROUTE_ERR_CHK_EN drops out-of-mesh packets.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module input_port_router
  import router_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CUR_X  = 0,
  parameter int CUR_Y  = 0,
  parameter int MESH_X = 4,
  parameter int MESH_Y = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_pkt,
  output logic [4:0]                 req,
  input  logic                       gnt,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_pkt,
  output logic [4:0]                 out_dir,
  output logic [$clog2(DEPTH):0]     count
`ifdef ROUTE_ERR_CHK_EN
  ,
  output logic                       err_drop,
  output logic [7:0]                 err_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] data_mem  [DEPTH];
  dir_t              route_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  coord_t in_dst_x;
  coord_t in_dst_y;
  dir_t   in_route;

  logic push;
  logic wr_en;
  logic pop;

  assign in_dst_x = in_pkt[DST_X_MSB:DST_X_LSB];
  assign in_dst_y = in_pkt[DST_Y_MSB:DST_Y_LSB];

  xy_route_calc #(
    .CUR_X (CUR_X),
    .CUR_Y (CUR_Y)
  ) u_route (
    .dst_x (in_dst_x),
    .dst_y (in_dst_y),
    .dir   (in_route)
  );

  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready && !rst;
  assign pop      = gnt && (count != '0) && !rst;

`ifdef ROUTE_ERR_CHK_EN
  logic bad_dst;

  // Out-of-mesh packets are consumed from the link but never stored.
  assign bad_dst  = (int'(in_dst_x) >= MESH_X) || (int'(in_dst_y) >= MESH_Y);
  assign wr_en    = push && !bad_dst;
  assign err_drop = push && bad_dst;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_drop && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  logic unused_mesh;

  assign unused_mesh = (MESH_X > 0) && (MESH_Y > 0);
  assign wr_en       = push;
`endif

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_ptr]  <= in_pkt;
      route_mem[wr_ptr] <= in_route;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign req       = (count != '0) ? route_mem[rd_ptr] : 5'b00000;
  assign out_valid = pop;
  assign out_pkt   = data_mem[rd_ptr];
  assign out_dir   = route_mem[rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_input_port_router.sv
// Testbench for input_port_router: queue-based reference model checked every cycle,
// plus directed literal expectations.
`default_nettype none

module tb_input_port_router;
  import router_pkg::*;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pkt;
  logic [4:0]        req;
  logic              gnt;
  logic              out_valid;
  logic [DATA_W-1:0] out_pkt;
  logic [4:0]        out_dir;
  logic [2:0]        count;
`ifdef ROUTE_ERR_CHK_EN
  logic              err_drop;
  logic [7:0]        err_cnt;
`endif

  always #5 clk = ~clk;

  input_port_router #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CUR_X  (1),
    .CUR_Y  (1),
    .MESH_X (4),
    .MESH_Y (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pkt    (in_pkt),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_pkt   (out_pkt),
    .out_dir   (out_dir),
    .count     (count)
`ifdef ROUTE_ERR_CHK_EN
    ,
    .err_drop  (err_drop),
    .err_cnt   (err_cnt)
`endif
  );

  logic [DATA_W-1:0] mq[$];
  int model_err = 0;
  int nvec = 0;
  int nmis = 0;

  function automatic logic [4:0] ref_route(input logic [DATA_W-1:0] p);
    int dx;
    int dy;
    dx = int'(p[7:4]);
    dy = int'(p[3:0]);
    if (dx > 1) return 5'b00100;
    if (dx < 1) return 5'b10000;
    if (dy > 1) return 5'b00010;
    if (dy < 1) return 5'b01000;
    return 5'b00001;
  endfunction

  function automatic bit ref_bad(input logic [DATA_W-1:0] p);
`ifdef ROUTE_ERR_CHK_EN
    return (int'(p[7:4]) >= 4) || (int'(p[3:0]) >= 4);
`else
    return (p[0] === 1'bx);
`endif
  endfunction

  function automatic logic [DATA_W-1:0] mkpkt(input int x, input int y);
    logic [DATA_W-1:0] p;
    p = {$urandom(), $urandom()};
    p[7:4] = 4'(x);
    p[3:0] = 4'(y);
    return p;
  endfunction

  task automatic cmp(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_now();
    bit ev;
    ev = !rst && gnt && (mq.size() != 0);
    cmp("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    cmp("count", 64'(count), 64'(mq.size()));
    cmp("req", 64'(req), (mq.size() != 0) ? 64'(ref_route(mq[0])) : 64'(0));
    cmp("out_valid", 64'(out_valid), 64'(ev));
    if (ev) begin
      cmp("out_pkt", out_pkt, mq[0]);
      cmp("out_dir", 64'(out_dir), 64'(ref_route(mq[0])));
    end
`ifdef ROUTE_ERR_CHK_EN
    cmp("err_drop", 64'(err_drop),
        64'(!rst && in_valid && (mq.size() != DEPTH) && ref_bad(in_pkt)));
    cmp("err_cnt", 64'(err_cnt), 64'(model_err));
`endif
  endtask

  task automatic model_update();
    bit do_pop;
    bit do_push;
    if (rst) begin
      mq.delete();
      model_err = 0;
    end else begin
      do_pop  = gnt && (mq.size() != 0);
      do_push = in_valid && (mq.size() != DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (ref_bad(in_pkt)) begin
          if (model_err < 255) model_err++;
        end else begin
          mq.push_back(in_pkt);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_now();
    @(posedge clk);
    model_update();
    #1;
  endtask

  int          dxs [5] = '{2, 0, 1, 1, 1};
  int          dys [5] = '{1, 1, 3, 0, 1};
  logic [4:0]  exps[5] = '{5'b00100, 5'b10000, 5'b00010, 5'b01000, 5'b00001};
  logic [DATA_W-1:0] fill[5];

  initial begin
    rst = 1'b1; in_valid = 1'b0; gnt = 1'b0; in_pkt = '0;
    @(posedge clk);
    model_update();
    #1;
    tick();
    rst = 1'b0;
    tick(); tick();
    cmp("rst_req", 64'(req), 64'(0));
    cmp("rst_in_ready", 64'(in_ready), 64'(1));
    cmp("rst_count", 64'(count), 64'(0));
    cmp("rst_out_valid", 64'(out_valid), 64'(0));

    // Each route direction, granted two cycles after push.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pkt = mkpkt(dxs[i], dys[i]);
      cmp("model_route", 64'(ref_route(in_pkt)), 64'(exps[i]));
      tick();
      in_valid = 1'b0;
      cmp("lit_req", 64'(req), 64'(exps[i]));
      tick();
      gnt = 1'b1;
      #1;
      cmp("lit_out_dir", 64'(out_dir), 64'(exps[i]));
      cmp("lit_out_valid", 64'(out_valid), 64'(1));
      tick();
      gnt = 1'b0;
    end

    // Fill to full with a held fifth packet.
    for (int i = 0; i < 5; i++) fill[i] = mkpkt(i % 4, 2);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_pkt = fill[i];
      tick();
    end
    cmp("full_count", 64'(count), 64'(4));
    cmp("full_in_ready", 64'(in_ready), 64'(0));
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    cmp("pop_full_count", 64'(count), 64'(3));
    tick();
    cmp("refill_count", 64'(count), 64'(4));
    in_valid = 1'b0;
    gnt = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    gnt = 1'b0;

    // Steady push and pop across pointer wrap.
    in_valid = 1'b1;
    in_pkt = mkpkt(3, 0);
    tick();
    gnt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_pkt = mkpkt(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      tick();
      cmp("steady_count", 64'(count), 64'(1));
    end
    in_valid = 1'b0;
    tick();
    gnt = 1'b0;

    // Grant while empty.
    gnt = 1'b1;
    #1;
    cmp("empty_gnt_out_valid", 64'(out_valid), 64'(0));
    tick();
    gnt = 1'b0;
    cmp("empty_gnt_count", 64'(count), 64'(0));

    // Reset with three entries buffered.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pkt = mkpkt(2, i);
      tick();
    end
    in_valid = 1'b0;
    cmp("pre_rst_count", 64'(count), 64'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("mid_rst_count", 64'(count), 64'(0));
    cmp("mid_rst_req", 64'(req), 64'(0));

`ifdef ROUTE_ERR_CHK_EN
    in_valid = 1'b1;
    in_pkt = mkpkt(5, 0);
    #1;
    cmp("lit_err_drop", 64'(err_drop), 64'(1));
    tick();
    in_valid = 1'b0;
    cmp("lit_err_cnt1", 64'(err_cnt), 64'(1));
    cmp("lit_err_count", 64'(count), 64'(0));
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_pkt = mkpkt(int'($urandom_range(4, 15)), int'($urandom_range(0, 15)));
      tick();
    end
    in_valid = 1'b0;
    cmp("lit_err_sat", 64'(err_cnt), 64'(255));
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      gnt = $urandom_range(0, 2) != 0;
`ifdef ROUTE_ERR_CHK_EN
      in_pkt = mkpkt(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
`else
      in_pkt = mkpkt(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
`endif
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; gnt = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
